// File: rtl/navic_gen_scheduler.sv
// rtl/navic_gen_scheduler.sv - round-robin time-division scheduler for a shared NavIC L1 pilot code generator
// Optional invalid-PRN rejection at arbitration: NAVIC_SCHED_PRN_CHECK_EN
module navic_gen_scheduler #(
  parameter int NCH     = 4,
  parameter int EPOCH_W = 8,
  parameter int MAX_PRN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [6*NCH-1:0]       prn_flat,
  input  logic [EPOCH_W*NCH-1:0] dwell_flat,
  input  logic                   epoch_in,
  output logic [NCH-1:0]         gnt,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         err,
  output logic [5:0]             gen_prn,
  output logic                   gen_rst,
  output logic                   gen_ena,
  output logic                   busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               nxt_state;

  logic [PW-1:0]        ptr;
  logic [PW-1:0]        win_q;
  logic [EPOCH_W-1:0]   dwell_q;
  logic [EPOCH_W-1:0]   ep_cnt;

  logic [PW-1:0]        nxt_ptr;
  logic [PW-1:0]        nxt_win;
  logic [EPOCH_W-1:0]   nxt_dwell;
  logic [EPOCH_W-1:0]   nxt_cnt;
  logic [NCH-1:0]       nxt_gnt;
  logic [NCH-1:0]       nxt_done;
  logic [NCH-1:0]       nxt_err;
  logic [5:0]           nxt_gen_prn;
  logic                 nxt_gen_rst;
  logic                 nxt_gen_ena;
  logic                 nxt_busy;

  logic [5:0]           prn_arr   [NCH];
  logic [EPOCH_W-1:0]   dwell_arr [NCH];

  logic                 found;
  logic [PW-1:0]        win;
  logic [PW-1:0]        idx;
  int                   sum;

  logic [5:0]           cand_prn;
  logic [EPOCH_W-1:0]   cand_dwell;
  logic                 prn_bad;
  logic [NCH-1:0]       win_onehot;
  logic [NCH-1:0]       cur_onehot;
  logic                 last_epoch;

  // Unpack the flat per-channel buses into indexable arrays
  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign prn_arr[i]   = prn_flat[6*i +: 6];
    assign dwell_arr[i] = dwell_flat[EPOCH_W*i +: EPOCH_W];
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = 0;
    for (int k = 1; k <= NCH; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NCH) sum = sum - NCH;
      idx = PW'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign cand_prn   = prn_arr[win];
  assign cand_dwell = (dwell_arr[win] == '0) ? EPOCH_W'(1) : dwell_arr[win];
  assign win_onehot = {{(NCH-1){1'b0}}, 1'b1} << win;
  assign cur_onehot = {{(NCH-1){1'b0}}, 1'b1} << win_q;
  assign last_epoch = epoch_in && (ep_cnt == (dwell_q - EPOCH_W'(1)));

`ifdef NAVIC_SCHED_PRN_CHECK_EN
  assign prn_bad = (cand_prn == 6'd0) || (cand_prn > 6'(MAX_PRN));
`else
  assign prn_bad = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ptr     <= PW'(NCH - 1);
      win_q   <= '0;
      dwell_q <= EPOCH_W'(1);
      ep_cnt  <= '0;
      gnt     <= '0;
      done    <= '0;
      err     <= '0;
      gen_prn <= 6'd1;
      gen_rst <= 1'b1;
      gen_ena <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= nxt_state;
      ptr     <= nxt_ptr;
      win_q   <= nxt_win;
      dwell_q <= nxt_dwell;
      ep_cnt  <= nxt_cnt;
      gnt     <= nxt_gnt;
      done    <= nxt_done;
      err     <= nxt_err;
      gen_prn <= nxt_gen_prn;
      gen_rst <= nxt_gen_rst;
      gen_ena <= nxt_gen_ena;
      busy    <= nxt_busy;
    end
  end

  // Next-state and next-output logic; defaults describe an idle, reset generator
  always_comb begin
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_win     = win_q;
    nxt_dwell   = dwell_q;
    nxt_cnt     = ep_cnt;
    nxt_gnt     = gnt;
    nxt_done    = '0;
    nxt_err     = '0;
    nxt_gen_prn = gen_prn;
    nxt_gen_rst = 1'b1;
    nxt_gen_ena = 1'b0;
    nxt_busy    = 1'b0;

    unique case (state)
      S_IDLE: begin
        nxt_gnt = '0;
        if (found && prn_bad) begin
          // Rejected requester still advances the pointer so others get a turn
          nxt_err = win_onehot;
          nxt_ptr = win;
        end else if (found) begin
          nxt_state   = S_LOAD;
          nxt_ptr     = win;
          nxt_win     = win;
          nxt_dwell   = cand_dwell;
          nxt_cnt     = '0;
          nxt_gnt     = win_onehot;
          nxt_gen_prn = cand_prn;
          nxt_busy    = 1'b1;
        end
      end

      S_LOAD: begin
        nxt_state   = S_RUN;
        nxt_gen_rst = 1'b0;
        nxt_gen_ena = 1'b1;
        nxt_busy    = 1'b1;
      end

      S_RUN: begin
        if (last_epoch) begin
          // Completion takes priority over a simultaneous request drop
          nxt_state = S_DONE;
          nxt_done  = cur_onehot;
          nxt_gnt   = '0;
          nxt_busy  = 1'b1;
        end else if (!req[win_q]) begin
          nxt_state = S_IDLE;
          nxt_gnt   = '0;
        end else begin
          if (epoch_in) nxt_cnt = ep_cnt + EPOCH_W'(1);
          nxt_gen_rst = 1'b0;
          nxt_gen_ena = 1'b1;
          nxt_busy    = 1'b1;
        end
      end

      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_gnt   = '0;
      end

      default: begin
        nxt_state = S_IDLE;
        nxt_gnt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_navic_gen_scheduler.sv
// tb/tb_navic_gen_scheduler.sv - directed self-checking bench for navic_gen_scheduler
module tb_navic_gen_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [23:0] prn_flat;
  logic [31:0] dwell_flat;
  logic        epoch_in;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic [5:0]  gen_prn;
  logic        gen_rst;
  logic        gen_ena;
  logic        busy;

  int checks;
  int errors;
  int order [5];
  int w;

  navic_gen_scheduler #(.NCH(4), .EPOCH_W(8), .MAX_PRN(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .prn_flat   (prn_flat),
    .dwell_flat (dwell_flat),
    .epoch_in   (epoch_in),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .gen_prn    (gen_prn),
    .gen_rst    (gen_rst),
    .gen_ena    (gen_ena),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_prn(input int ch, input logic [5:0] v);
    prn_flat[6*ch +: 6] = v;
  endtask

  task automatic set_dwell(input int ch, input logic [7:0] v);
    dwell_flat[8*ch +: 8] = v;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_gnt"},     32'(gnt),     32'h0);
    check({pfx, "_done"},    32'(done),    32'h0);
    check({pfx, "_err"},     32'(err),     32'h0);
    check({pfx, "_gen_prn"}, 32'(gen_prn), 32'd1);
    check({pfx, "_gen_rst"}, 32'(gen_rst), 32'd1);
    check({pfx, "_gen_ena"}, 32'(gen_ena), 32'd0);
    check({pfx, "_busy"},    32'(busy),    32'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req        = 4'b0000;
    prn_flat   = '0;
    dwell_flat = '0;
    epoch_in   = 1'b0;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request: ch0, PRN 3, dwell 2, strobe every 20 cycles
    set_prn(0, 6'd3);
    set_dwell(0, 8'd2);
    req = 4'b0001;
    tick();
    check("single_load_gnt", 32'(gnt),     32'h1);
    check("single_load_rst", 32'(gen_rst), 32'd1);
    check("single_load_prn", 32'(gen_prn), 32'd3);
    check("single_load_ena", 32'(gen_ena), 32'd0);
    check("single_load_busy", 32'(busy),   32'd1);
    tick();
    check("single_run_ena", 32'(gen_ena), 32'd1);
    check("single_run_rst", 32'(gen_rst), 32'd0);
    repeat (18) tick();
    epoch_in = 1'b1;
    tick();
    epoch_in = 1'b0;
    check("single_ep1_done", 32'(done),    32'h0);
    check("single_ep1_ena",  32'(gen_ena), 32'd1);
    repeat (19) tick();
    epoch_in = 1'b1;
    tick();
    epoch_in = 1'b0;
    check("single_done",      32'(done),    32'h1);
    check("single_done_gnt",  32'(gnt),     32'h0);
    check("single_done_ena",  32'(gen_ena), 32'd0);
    check("single_done_rst",  32'(gen_rst), 32'd1);
    check("single_done_busy", 32'(busy),    32'd1);
    req = 4'b0000;
    tick();
    check("single_after_done", 32'(done),    32'h0);
    check("single_after_busy", 32'(busy),    32'd0);
    check("single_prn_hold",   32'(gen_prn), 32'd3);

    // Round-robin from a fresh pointer: 0,1,2,3,0 with two gap cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_prn(0, 6'd1); set_prn(1, 6'd2); set_prn(2, 6'd3); set_prn(3, 6'd4);
    dwell_flat = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b1111;
    tick();
    for (int i = 0; i < 5; i++) begin
      w = order[i];
      check("rr_gnt", 32'(gnt),     32'(1) << w);
      check("rr_prn", 32'(gen_prn), 32'(w + 1));
      tick();
      check("rr_ena", 32'(gen_ena), 32'd1);
      epoch_in = 1'b1;
      tick();
      epoch_in = 1'b0;
      check("rr_done",     32'(done), 32'(1) << w);
      check("rr_done_gnt", 32'(gnt),  32'h0);
      tick();
      check("rr_idle_gnt",  32'(gnt),  32'h0);
      check("rr_idle_busy", 32'(busy), 32'd0);
      if (i == 4) req = 4'b0000;
      tick();
    end
    check("rr_end_gnt", 32'(gnt), 32'h0);

    // Abort ch1 mid-RUN while ch2 waits
    set_prn(1, 6'd2); set_dwell(1, 8'd3);
    set_prn(2, 6'd3); set_dwell(2, 8'd0);
    req = 4'b0010;
    tick();
    check("abort_load_gnt", 32'(gnt),     32'h2);
    check("abort_load_prn", 32'(gen_prn), 32'd2);
    tick();
    tick();
    req = 4'b0110;
    tick();
    check("abort_hold_gnt", 32'(gnt), 32'h2);
    req = 4'b0100;
    tick();
    check("abort_gnt",  32'(gnt),     32'h0);
    check("abort_ena",  32'(gen_ena), 32'd0);
    check("abort_done", 32'(done),    32'h0);
    check("abort_busy", 32'(busy),    32'd0);
    tick();
    check("abort_next_gnt", 32'(gnt),     32'h4);
    check("abort_next_prn", 32'(gen_prn), 32'd3);

    // Dwell 0 acts as 1; late PRN change ignored; final strobe with req drop completes
    set_prn(2, 6'd5);
    tick();
    check("d0_run_prn", 32'(gen_prn), 32'd3);
    check("d0_run_ena", 32'(gen_ena), 32'd1);
    epoch_in = 1'b1;
    req = 4'b0000;
    tick();
    epoch_in = 1'b0;
    check("d0_done",     32'(done), 32'h4);
    check("d0_done_gnt", 32'(gnt),  32'h0);
    tick();
    check("d0_after_done", 32'(done), 32'h0);

    // Reset mid-RUN: outputs back to reset values and pointer restarts at ch0
    set_prn(0, 6'd3);
    set_dwell(0, 8'd5);
    req = 4'b0001;
    tick();
    check("rstrun_load_gnt", 32'(gnt), 32'h1);
    tick();
    epoch_in = 1'b1;
    tick();
    epoch_in = 1'b0;
    req   = 4'b0011;
    reset = 1'b1;
    tick();
    check_reset_outputs("rstrun");
    reset = 1'b0;
    tick();
    check("rstrun_next_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    tick();
    check("rstrun_abort_gnt",  32'(gnt),  32'h0);
    check("rstrun_abort_busy", 32'(busy), 32'd0);

    // PRN 0 on ch2: rejected with the check enabled, forwarded otherwise
    set_prn(2, 6'd0);
    req = 4'b0100;
    tick();
`ifdef NAVIC_SCHED_PRN_CHECK_EN
    check("prn0_err",  32'(err),  32'h4);
    check("prn0_gnt",  32'(gnt),  32'h0);
    check("prn0_busy", 32'(busy), 32'd0);
    req = 4'b0000;
    tick();
    check("prn0_err_clear", 32'(err), 32'h0);
    check("prn0_idle_gnt",  32'(gnt), 32'h0);
`else
    check("prn0_gnt",     32'(gnt),     32'h4);
    check("prn0_gen_prn", 32'(gen_prn), 32'd0);
    check("prn0_err",     32'(err),     32'h0);
    req = 4'b0000;
    tick();
    tick();
    check("prn0_abort_gnt", 32'(gnt), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/navic_gen_scheduler.md
# navic_gen_scheduler

Time-division scheduler sharing one NavIC L1 pilot code generator among up to `NCH` requesting channels. It performs round-robin arbitration between requesters and loads the winner's PRN ID into the generator. It resets the generator so the PRN's initial conditions are loaded, then enables it for a requested number of primary-code epochs. Finally it releases the generator and signals completion. It sits between the acquisition/tracking channel logic and the pilot generator's `prn_id`/`rst_n`/`ena` inputs.

## Interface
Parameters:
- `NCH`, 4: number of requesting channels (2..8).
- `EPOCH_W`, 8: width of per-channel dwell count.
- `MAX_PRN`, 5: highest PRN ID the generator supports.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req`  in  NCH  per-channel request level.
- `prn_flat`  in  6*NCH  PRN ID of channel i at bits [6i+5:6i].
- `dwell_flat`  in  EPOCH_W*NCH  epochs requested by channel i; 0 is treated as 1.
- `epoch_in`  in  1  generator primary-epoch strobe, one cycle per 10230 enabled chips.
- `gnt`  out  NCH  one-hot grant; held from arbitration until `done` or abort.
- `done`  out  NCH  one-cycle pulse when the granted dwell completes.
- `err`  out  NCH  one-cycle invalid-PRN pulse; only driven when the macro is defined.
- `gen_prn`  out  6  PRN ID to the generator.
- `gen_rst`  out  1  generator reset, active-high; the integrator inverts it to drive `rst_n`.
- `gen_ena`  out  1  generator enable.
- `busy`  out  1  high in LOAD, RUN and DONE.

## Operation
- Per-channel inputs are sampled only at the arbitration instant. Later changes to `prn_flat`/`dwell_flat` have no effect on the active grant.
- Round-robin pointer `ptr` holds the last granted index. The search starts at `ptr+1` mod NCH, so after reset channel 0 has first priority.
- FSM states:
  - **IDLE**: `gen_rst=1`, `gen_ena=0`, `gnt=0`. If any `req` is high, the winner `w` is chosen. The block latches `prn[w]` and `max(dwell[w],1)`, sets `ptr=w`, sets `gnt[w]`, clears the epoch counter and goes to LOAD.
  - **LOAD** (exactly 1 cycle): `gen_prn`=latched PRN, `gen_rst=1`, `gen_ena=0`. Next state is RUN.
  - **RUN**: `gen_rst=0`, `gen_ena=1`. Each `epoch_in` increments the epoch counter.
    - When `epoch_in` arrives with counter == dwell-1, the next state is DONE.
    - If `req[w]` is low, the block aborts to IDLE. There is no `done` pulse, `gen_ena` drops next cycle and `ptr` is retained.
  - **DONE** (1 cycle): `done[w]=1`, `gnt=0`, `gen_ena=0`, `gen_rst=1`. Next state is IDLE.
- Simultaneous final `epoch_in` and `req[w]` low in RUN: completion wins, so `done[w]` pulses.
- `epoch_in` outside RUN is ignored.
- The requester must drop `req` after `done` if no further dwell is wanted. A still-high `req` re-competes normally behind the other channels.
- `gen_prn` holds its last value in IDLE/DONE.
- The epoch counter is EPOCH_W bits and cannot wrap, because its maximum value is dwell-1.

## Timing
- Reset values: state IDLE, `ptr`=NCH-1, `gnt=0`, `done=0`, `err=0`, `gen_prn=6'd1`, `gen_rst=1`, `gen_ena=0`, `busy=0`.
- All outputs are registered.
- Sequence for a request first seen high in IDLE at cycle T:
  - `gnt` and `busy` go high at T+1 (LOAD, `gen_rst=1`, new `gen_prn`).
  - `gen_ena` goes high at T+2.
  - With the real generator, the first `epoch_in` arrives 10230 enabled cycles later.
- The final `epoch_in` at cycle E produces `done` at E+1, with `gnt=0` and `gen_ena=0`. The earliest next grant is at E+3.
- Reset asserted mid-operation returns every output to its reset value on the next edge, with no `done` pulse.

## Configuration
- `NAVIC_SCHED_PRN_CHECK_EN` defined: at arbitration, if the winner's PRN is 0 or greater than `MAX_PRN`, no grant is issued. Instead `err[w]` pulses for one cycle, `ptr=w`, and the state stays IDLE. The next arbitration runs the following cycle.
- Not defined: `err` is tied to 0 and any PRN is forwarded unchecked. The generator falls back to PRN 1 for unsupported IDs.

## Test plan
- **Single request:** reset, then `req[0]`=1, `prn0`=3, `dwell0`=2, with the bench pulsing `epoch_in` every 20 cycles.
  - Expect `gnt`=0001 at T+1, one-cycle `gen_rst` and `gen_prn`=3, and `gen_ena` at T+2.
  - Expect `done[0]` one cycle after the 2nd strobe.
- **Round-robin:** `req`=1111 held continuously, all dwell 1. Grants must follow the order 0,1,2,3,0, with exactly 2 idle cycles (DONE, IDLE) between grants.
- **Abort:** drop `req[1]` mid-RUN. `gen_ena`=0 and `gnt`=0 next cycle, no `done[1]`, and `req[2]` is granted in the following arbitration.
- **Dwell 0 and simultaneous events:** `dwell`=0 must complete after 1 strobe. A final strobe in the same cycle as `req` falling must still produce `done`.
- **Reset mid-RUN:** all outputs return to reset values, and the next grant goes to channel 0 despite the previous `ptr`.
- **Macro on:** `prn2`=0 with `req`=0100 gives an `err[2]` pulse, no `gnt`, and a state that stays IDLE. With the macro off, the same stimulus is granted with `gen_prn`=0.
